// File: rtl/multi_fifo_channel_pkg.sv
// -----------------------------------------------------------------------------
// multi_fifo_channel_pkg
// Shared constants and helpers for the multi-channel FIFO.
//   DROP_CNT_W : width of each per-channel saturating drop counter
//   calcChW()  : width of the channel-index field (at least 1 bit)
// -----------------------------------------------------------------------------
package multi_fifo_channel_pkg;

  localparam int DROP_CNT_W = 16;

  // A channel index needs clog2(N) bits, but never fewer than one so that
  // the pop_channel port always exists.
  function automatic int calcChW(input int numChannels);
    int w;
    w = $clog2(numChannels);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_fifo_channel_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo_channel
// Single-channel synchronous FIFO of 2**LOG_DEPTH entries with a registered
// occupancy count. Pushes are refused when full at the start of the cycle,
// even if a pop happens in the same cycle.
// Ports:
//   clk, clear     : clock, asynchronous active-high reset
//   i_pushEn       : write request (ignored when full)
//   i_pushData     : write payload
//   i_popEn        : dequeue the head entry (ignored when empty)
//   o_headData     : current head entry (valid when not empty)
//   o_occupancy    : number of stored entries, 0..2**LOG_DEPTH
//   o_full/o_empty : occupancy at its limits
// -----------------------------------------------------------------------------
module sync_fifo_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 5
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  i_pushEn,
  input  logic [DATA_WIDTH-1:0] i_pushData,
  input  logic                  i_popEn,
  output logic [DATA_WIDTH-1:0] o_headData,
  output logic [LOG_DEPTH:0]    o_occupancy,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int CW    = LOG_DEPTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [LOG_DEPTH-1:0]  r_wrPtr;
  logic [LOG_DEPTH-1:0]  r_rdPtr;
  logic [CW-1:0]         r_count;

  logic w_pushAccept;
  logic w_popDo;

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_occupancy  = r_count;
  assign o_headData   = r_mem[r_rdPtr];
  assign w_pushAccept = i_pushEn && !o_full;
  assign w_popDo      = i_popEn && !o_empty;

  // Storage array; deliberately not reset, stale contents are never read
  // because the pointers and count are.
  always_ff @(posedge clk) begin
    if (w_pushAccept) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally at LOG_DEPTH bits; a simultaneous push and pop
  // leaves the count untouched.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushAccept) begin
        r_wrPtr <= r_wrPtr + LOG_DEPTH'(1);
      end
      if (w_popDo) begin
        r_rdPtr <= r_rdPtr + LOG_DEPTH'(1);
      end
      case ({w_pushAccept, w_popDo})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/multi_fifo_channel.sv
// -----------------------------------------------------------------------------
// multi_fifo_channel
// NUM_CHANNELS independent input FIFOs merged by a round-robin arbiter into a
// single registered output stage.
// Ports:
//   clk, clear        : clock, asynchronous active-high reset
//   push_en/push_data : per-channel push request and payload (channel i at
//                       bits [i*DATA_WIDTH +: DATA_WIDTH])
//   push_almost_full  : per-channel occupancy >= ALMOST_FULL_TH
//   pop_ready         : consumer accepts the output entry
//   pop_valid/pop_data/pop_channel : output stage contents
//   pop_dw            : per-channel FIFO occupancy (output stage excluded)
//   drop_count        : per-channel saturating count of refused pushes
//   error             : per-channel sticky overflow flag
// -----------------------------------------------------------------------------
module multi_fifo_channel
  import multi_fifo_channel_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int LOG_DEPTH      = 5,
  parameter  int NUM_CHANNELS   = 4,
  parameter  int ALMOST_FULL_TH = 2**LOG_DEPTH - 4,
  localparam int CH_W           = calcChW(NUM_CHANNELS)
) (
  input  logic                                 clk,
  input  logic                                 clear,
  input  logic [NUM_CHANNELS-1:0]              push_en,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   push_data,
  output logic [NUM_CHANNELS-1:0]              push_almost_full,
  input  logic                                 pop_ready,
  output logic                                 pop_valid,
  output logic [DATA_WIDTH-1:0]                pop_data,
  output logic [CH_W-1:0]                      pop_channel,
  output logic [NUM_CHANNELS*(LOG_DEPTH+1)-1:0] pop_dw,
  output logic [NUM_CHANNELS*DROP_CNT_W-1:0]   drop_count,
  output logic [NUM_CHANNELS-1:0]              error
);

  logic [NUM_CHANNELS-1:0] w_empty;
  logic [NUM_CHANNELS-1:0] w_full;
  logic [NUM_CHANNELS-1:0] w_popSel;
  logic [NUM_CHANNELS-1:0] w_pushReject;
  logic [DATA_WIDTH-1:0]   w_head [NUM_CHANNELS];
  logic [LOG_DEPTH:0]      w_occ  [NUM_CHANNELS];

  logic                    w_loadable;
  logic                    w_grantValid;
  logic                    w_doGrant;
  logic [CH_W-1:0]         w_grantIdx;

  logic                    r_popValid;
  logic [DATA_WIDTH-1:0]   r_popData;
  logic [CH_W-1:0]         r_popChannel;
  logic [CH_W-1:0]         r_lastGrant;
  logic [DROP_CNT_W-1:0]   r_dropCnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_error;

  // One FIFO per channel plus the flattened status outputs.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gen_ch
    sync_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG_DEPTH  (LOG_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .clear       (clear),
      .i_pushEn    (push_en[g]),
      .i_pushData  (push_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_popEn     (w_popSel[g]),
      .o_headData  (w_head[g]),
      .o_occupancy (w_occ[g]),
      .o_full      (w_full[g]),
      .o_empty     (w_empty[g])
    );

    assign pop_dw[g*(LOG_DEPTH+1) +: (LOG_DEPTH+1)]   = w_occ[g];
    assign push_almost_full[g]                        = (int'(w_occ[g]) >= ALMOST_FULL_TH);
    assign drop_count[g*DROP_CNT_W +: DROP_CNT_W]     = r_dropCnt[g];
    assign w_pushReject[g]                            = push_en[g] && w_full[g];
  end

  assign w_loadable  = !r_popValid || pop_ready;
  assign w_doGrant   = w_loadable && w_grantValid;
  assign pop_valid   = r_popValid;
  assign pop_data    = r_popData;
  assign pop_channel = r_popChannel;
  assign error       = r_error;

  // Round-robin search: the first non-empty channel after the last grant
  // wins. The index never exceeds 2*NUM_CHANNELS-1, so one subtraction is
  // enough to wrap it.
  always_comb begin
    int idx;
    idx          = 0;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = int'(r_lastGrant) + 1 + k;
      if (idx >= NUM_CHANNELS) begin
        idx = idx - NUM_CHANNELS;
      end
      if (!w_grantValid && !w_empty[idx]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = CH_W'(idx);
      end
    end
  end

  // One-hot dequeue strobe towards the granted FIFO.
  always_comb begin
    w_popSel = '0;
    if (w_doGrant) begin
      w_popSel[w_grantIdx] = 1'b1;
    end
  end

  // Output stage: reloads whenever it is empty or being consumed, otherwise
  // holds its contents. last_grant starts at the top channel so channel 0
  // is searched first after reset.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_popValid   <= 1'b0;
      r_popData    <= '0;
      r_popChannel <= '0;
      r_lastGrant  <= CH_W'(NUM_CHANNELS - 1);
    end else if (w_doGrant) begin
      r_popValid   <= 1'b1;
      r_popData    <= w_head[w_grantIdx];
      r_popChannel <= w_grantIdx;
      r_lastGrant  <= w_grantIdx;
    end else if (pop_ready) begin
      r_popValid   <= 1'b0;
    end
  end

  // Refused pushes bump a saturating counter and latch a sticky error flag.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_dropCnt[i] <= '0;
      end
      r_error <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_pushReject[i]) begin
          if (r_dropCnt[i] != {DROP_CNT_W{1'b1}}) begin
            r_dropCnt[i] <= r_dropCnt[i] + DROP_CNT_W'(1);
          end
          r_error[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_fifo_channel.sv
// -----------------------------------------------------------------------------
// tb_multi_fifo_channel
// Directed scenarios plus randomized traffic against a queue-based reference
// model of the multi-channel FIFO (default parameters: 4 x 32-entry x 32-bit).
// -----------------------------------------------------------------------------
module tb_multi_fifo_channel;

  localparam int NC    = 4;
  localparam int DW    = 32;
  localparam int LD    = 5;
  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int CW    = LD + 1;

  logic              clk;
  logic              clear;
  logic [NC-1:0]     push_en;
  logic [NC*DW-1:0]  push_data;
  logic [NC-1:0]     push_almost_full;
  logic              pop_ready;
  logic              pop_valid;
  logic [DW-1:0]     pop_data;
  logic [1:0]        pop_channel;
  logic [NC*CW-1:0]  pop_dw;
  logic [NC*16-1:0]  drop_count;
  logic [NC-1:0]     error;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [DW-1:0] mq [NC][$];
  bit            mValid;
  logic [DW-1:0] mData;
  int            mChan;
  int            mLast;
  int            mDrop [NC];
  bit            mErr  [NC];

  multi_fifo_channel dut (
    .clk              (clk),
    .clear            (clear),
    .push_en          (push_en),
    .push_data        (push_data),
    .push_almost_full (push_almost_full),
    .pop_ready        (pop_ready),
    .pop_valid        (pop_valid),
    .pop_data         (pop_data),
    .pop_channel      (pop_channel),
    .pop_dw           (pop_dw),
    .drop_count       (drop_count),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      mDrop[i] = 0;
      mErr[i]  = 1'b0;
    end
    mValid = 1'b0;
    mData  = '0;
    mChan  = 0;
    mLast  = NC - 1;
  endtask

  // One clock of behaviour: arbitration looks at occupancy before this
  // cycle's pushes, and pushes see capacity before this cycle's pop.
  task automatic modelStep(input logic [NC-1:0] pe, input logic [NC*DW-1:0] pd, input logic pr);
    int  startSize [NC];
    bit  loadable;
    bit  found;
    int  c;
    for (int i = 0; i < NC; i++) startSize[i] = mq[i].size();
    loadable = !mValid || pr;
    found    = 1'b0;
    if (loadable) begin
      for (int k = 1; k <= NC; k++) begin
        c = (mLast + k) % NC;
        if (!found && startSize[c] > 0) begin
          found = 1'b1;
          mData = mq[c].pop_front();
          mChan = c;
          mLast = c;
        end
      end
    end
    if (found)   mValid = 1'b1;
    else if (pr) mValid = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (pe[i]) begin
        if (startSize[i] < DEPTH) begin
          mq[i].push_back(pd[i*DW +: DW]);
        end else begin
          if (mDrop[i] != 16'hFFFF) mDrop[i]++;
          mErr[i] = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, land at posedge+1.
  task automatic applyStimulus(input logic [NC-1:0] pe, input logic [NC*DW-1:0] pd, input logic pr);
    push_en   = pe;
    push_data = pd;
    pop_ready = pr;
    modelStep(pe, pd, pr);
    @(posedge clk);
    #1;
  endtask

  task automatic applyClear();
    push_en   = '0;
    push_data = '0;
    pop_ready = 1'b0;
    clear     = 1'b1;
    #2;
    clear     = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear     = 1'b1;
    push_en   = '0;
    push_data = '0;
    pop_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL reset_pop_valid: got %0h expected 0", pop_valid); else passes++;
    checks++; if (pop_data !== '0) $display("[TB] FAIL reset_pop_data: got %0h expected 0", pop_data); else passes++;
    checks++; if (pop_channel !== 2'd0) $display("[TB] FAIL reset_pop_channel: got %0h expected 0", pop_channel); else passes++;
    checks++; if (pop_dw !== '0) $display("[TB] FAIL reset_pop_dw: got %0h expected 0", pop_dw); else passes++;
    checks++; if (drop_count !== '0) $display("[TB] FAIL reset_drop_count: got %0h expected 0", drop_count); else passes++;
    checks++; if (error !== '0) $display("[TB] FAIL reset_error: got %0h expected 0", error); else passes++;
    checks++; if (push_almost_full !== '0) $display("[TB] FAIL reset_almost_full: got %0h expected 0", push_almost_full); else passes++;
    clear = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL post_reset_idle: got %0h expected 0", pop_valid); else passes++;
  endtask

  task automatic test_latency();
    logic [NC*DW-1:0] pd;
    pd = '0;
    pd[2*DW +: DW] = 32'hA5;
    applyStimulus(4'b0100, pd, 1'b1);
    checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL latency_cycle1_valid: got %0h expected 0", pop_valid); else passes++;
    applyStimulus('0, '0, 1'b1);
    checks++; if (pop_valid !== 1'b1) $display("[TB] FAIL latency_cycle2_valid: got %0h expected 1", pop_valid); else passes++;
    checks++; if (pop_data !== 32'hA5) $display("[TB] FAIL latency_data: got %0h expected a5", pop_data); else passes++;
    checks++; if (pop_channel !== 2'd2) $display("[TB] FAIL latency_channel: got %0h expected 2", pop_channel); else passes++;
    applyStimulus('0, '0, 1'b1);
    checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL latency_drain_valid: got %0h expected 0", pop_valid); else passes++;
  endtask

  task automatic test_round_robin();
    logic [NC*DW-1:0] pd;
    applyClear();
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < NC; c++) pd[c*DW +: DW] = DW'(c*16 + j);
      applyStimulus(4'b1111, pd, 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      checks++; if (pop_valid !== 1'b1) $display("[TB] FAIL rr_valid[%0d]: got %0h expected 1", k, pop_valid); else passes++;
      checks++; if (pop_channel !== 2'(k % 4)) $display("[TB] FAIL rr_channel[%0d]: got %0d expected %0d", k, pop_channel, k % 4); else passes++;
      checks++; if (pop_data !== DW'((k % 4)*16 + k/4)) $display("[TB] FAIL rr_data[%0d]: got %0h expected %0h", k, pop_data, (k % 4)*16 + k/4); else passes++;
      applyStimulus('0, '0, 1'b1);
    end
    checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL rr_end_valid: got %0h expected 0", pop_valid); else passes++;
  endtask

  task automatic test_overflow();
    logic [NC*DW-1:0] pd;
    applyClear();
    for (int i = 0; i < 34; i++) begin
      checks++;
      if (push_almost_full[1] !== (mq[1].size() >= AF))
        $display("[TB] FAIL ovf_almost_full[%0d]: got %0h expected %0h (occ %0d)", i, push_almost_full[1], mq[1].size() >= AF, mq[1].size());
      else passes++;
      pd = '0;
      pd[1*DW +: DW] = DW'(i);
      applyStimulus(4'b0010, pd, 1'b0);
    end
    checks++; if (drop_count[16 +: 16] !== 16'd1) $display("[TB] FAIL ovf_drop_count: got %0d expected 1", drop_count[16 +: 16]); else passes++;
    checks++; if (error !== 4'b0010) $display("[TB] FAIL ovf_error: got %0h expected 2", error); else passes++;
    checks++; if (pop_dw[1*CW +: CW] !== 6'd32) $display("[TB] FAIL ovf_pop_dw: got %0d expected 32", pop_dw[1*CW +: CW]); else passes++;
    checks++; if (push_almost_full[1] !== 1'b1) $display("[TB] FAIL ovf_almost_full_end: got %0h expected 1", push_almost_full[1]); else passes++;
    for (int k = 0; k < 33; k++) begin
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== DW'(k))
        $display("[TB] FAIL ovf_drain[%0d]: got valid %0h data %0h expected valid 1 data %0h", k, pop_valid, pop_data, k);
      else passes++;
      applyStimulus('0, '0, 1'b1);
    end
    checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL ovf_drain_end: got %0h expected 0", pop_valid); else passes++;
  endtask

  task automatic test_full_push_pop();
    logic [NC*DW-1:0] pd;
    applyClear();
    for (int i = 0; i < 33; i++) begin
      pd = '0;
      pd[0 +: DW] = DW'(100 + i);
      applyStimulus(4'b0001, pd, 1'b0);
    end
    checks++; if (pop_dw[0 +: CW] !== 6'd32) $display("[TB] FAIL fpp_full_dw: got %0d expected 32", pop_dw[0 +: CW]); else passes++;
    pd = '0;
    pd[0 +: DW] = 32'hDEAD;
    applyStimulus(4'b0001, pd, 1'b1);
    checks++; if (drop_count[0 +: 16] !== 16'd1) $display("[TB] FAIL fpp_drop_count: got %0d expected 1", drop_count[0 +: 16]); else passes++;
    checks++; if (pop_dw[0 +: CW] !== 6'd31) $display("[TB] FAIL fpp_pop_dw: got %0d expected 31", pop_dw[0 +: CW]); else passes++;
    checks++; if (pop_data !== DW'(101)) $display("[TB] FAIL fpp_next_data: got %0h expected %0h", pop_data, 101); else passes++;
    checks++; if (error[0] !== 1'b1) $display("[TB] FAIL fpp_error: got %0h expected 1", error[0]); else passes++;
  endtask

  task automatic test_hold_and_clear();
    logic [NC*DW-1:0] pd;
    applyClear();
    for (int i = 0; i < 35; i++) begin
      pd = '0;
      pd[3*DW +: DW] = DW'(32'h300 + i);
      applyStimulus(4'b1000, pd, 1'b0);
    end
    checks++; if (drop_count[3*16 +: 16] !== 16'd2) $display("[TB] FAIL hold_drop_count: got %0d expected 2", drop_count[3*16 +: 16]); else passes++;
    checks++; if (error !== 4'b1000) $display("[TB] FAIL hold_error: got %0h expected 8", error); else passes++;
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== 32'h300 || pop_channel !== 2'd3)
        $display("[TB] FAIL hold_stable[%0d]: got valid %0h data %0h ch %0d expected valid 1 data 300 ch 3", h, pop_valid, pop_data, pop_channel);
      else passes++;
      applyStimulus('0, '0, 1'b0);
    end
    clear = 1'b1;
    #1;
    checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL clear_pop_valid: got %0h expected 0", pop_valid); else passes++;
    checks++; if (pop_dw !== '0) $display("[TB] FAIL clear_pop_dw: got %0h expected 0", pop_dw); else passes++;
    checks++; if (error !== '0) $display("[TB] FAIL clear_error: got %0h expected 0", error); else passes++;
    checks++; if (drop_count !== '0) $display("[TB] FAIL clear_drop_count: got %0h expected 0", drop_count); else passes++;
    checks++; if (pop_data !== '0) $display("[TB] FAIL clear_pop_data: got %0h expected 0", pop_data); else passes++;
    #1;
    clear = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    for (int h = 0; h < 4; h++) begin
      checks++; if (pop_valid !== 1'b0) $display("[TB] FAIL clear_no_output[%0d]: got %0h expected 0", h, pop_valid); else passes++;
      applyStimulus('0, '0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic [NC*DW-1:0] pd;
    logic [NC-1:0]    pe;
    logic             pr;
    int               pushPct;
    int               popPct;
    applyClear();
    for (int n = 0; n < 500; n++) begin
      pushPct = (n < 250) ? 70 : 15;
      popPct  = (n < 250) ? 20 : 95;
      checks++; if (pop_valid !== mValid) $display("[TB] FAIL rnd_valid[%0d]: got %0h expected %0h", n, pop_valid, mValid); else passes++;
      if (mValid) begin
        checks++; if (pop_data !== mData) $display("[TB] FAIL rnd_data[%0d]: got %0h expected %0h", n, pop_data, mData); else passes++;
        checks++; if (pop_channel !== 2'(mChan)) $display("[TB] FAIL rnd_channel[%0d]: got %0d expected %0d", n, pop_channel, mChan); else passes++;
      end
      for (int i = 0; i < NC; i++) begin
        checks++; if (pop_dw[i*CW +: CW] !== CW'(mq[i].size())) $display("[TB] FAIL rnd_dw[%0d][%0d]: got %0d expected %0d", n, i, pop_dw[i*CW +: CW], mq[i].size()); else passes++;
        checks++; if (push_almost_full[i] !== (mq[i].size() >= AF)) $display("[TB] FAIL rnd_af[%0d][%0d]: got %0h expected %0h", n, i, push_almost_full[i], mq[i].size() >= AF); else passes++;
        checks++; if (drop_count[i*16 +: 16] !== 16'(mDrop[i])) $display("[TB] FAIL rnd_drop[%0d][%0d]: got %0d expected %0d", n, i, drop_count[i*16 +: 16], mDrop[i]); else passes++;
        checks++; if (error[i] !== mErr[i]) $display("[TB] FAIL rnd_error[%0d][%0d]: got %0h expected %0h", n, i, error[i], mErr[i]); else passes++;
      end
      for (int i = 0; i < NC; i++) begin
        pe[i] = ($urandom_range(0, 99) < pushPct);
        pd[i*DW +: DW] = $urandom;
      end
      pr = ($urandom_range(0, 99) < popPct);
      applyStimulus(pe, pd, pr);
    end
  endtask

  initial begin
    $display("[TB] starting multi_fifo_channel bench");
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_full_push_pop();
    test_hold_and_clear();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_fifo_channel.md
MULTI_FIFO_CHANNEL -- requirements
Module: multi_fifo_channel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width per entry.
REQ-002 SHALL have parameter LOG_DEPTH, default 5: per-channel depth is 2**LOG_DEPTH entries.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, legal range 2..16: number of independent input FIFOs.
REQ-004 SHALL have parameter ALMOST_FULL_TH, default 2**LOG_DEPTH-4: occupancy at or above which almost-full asserts.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  sole clock, all state on rising edge.
REQ-006 clear  in  1  asynchronous active-high reset.
REQ-007 push_en  in  NUM_CHANNELS  per-channel push request.
REQ-008 push_data  in  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 push_almost_full  out  NUM_CHANNELS  per-channel occupancy >= ALMOST_FULL_TH.
REQ-010 pop_ready  in  1  consumer accepts the output entry.
REQ-011 pop_valid  out  1  output stage holds a valid entry.
REQ-012 pop_data  out  DATA_WIDTH  output entry payload.
REQ-013 pop_channel  out  CH_W = max(1, clog2(NUM_CHANNELS))  source channel of pop_data.
REQ-014 pop_dw  out  NUM_CHANNELS*(LOG_DEPTH+1)  per-channel FIFO occupancy, output stage excluded.
REQ-015 drop_count  out  NUM_CHANNELS*16  per-channel saturating count of dropped pushes.
REQ-016 error  out  NUM_CHANNELS  per-channel sticky overflow flag.

Function
REQ-017 Each channel SHALL be a synchronous FIFO of 2**LOG_DEPTH entries; occupancy is LOG_DEPTH+1 bits, range 0..2**LOG_DEPTH.
REQ-018 Push on channel i SHALL be accepted iff push_en[i] and occupancy at the start of the cycle < 2**LOG_DEPTH; a same-cycle dequeue SHALL NOT free space for that push.
REQ-019 A rejected push SHALL increment drop_count[i] (saturating at 16'hFFFF) and set error[i], which stays 1 until clear.
REQ-020 Read/write pointers SHALL wrap modulo 2**LOG_DEPTH; simultaneous push and dequeue on one channel SHALL leave occupancy unchanged.
REQ-021 The output stage SHALL be a single register (pop_valid, pop_data, pop_channel); it is loadable when pop_valid=0 or pop_ready=1.
REQ-022 When loadable and any channel is non-empty, a round-robin arbiter SHALL grant one channel, dequeue its head into the output stage, and set pop_valid=1; otherwise pop_valid SHALL go 0 if pop_ready=1.
REQ-023 Round-robin: search starts at last_grant+1 mod NUM_CHANNELS; last_grant updates to the granted channel only on a grant.
REQ-024 pop_valid=1 with pop_ready=0 SHALL hold pop_data and pop_channel stable.
REQ-025 Latency: an entry pushed in cycle n into an empty channel, with output stage loadable and the channel winning, SHALL appear with pop_valid=1 in cycle n+2.
REQ-026 Throughput: with pop_ready held 1 and at least one channel non-empty, one entry per cycle SHALL be delivered.
REQ-027 Per-channel ordering SHALL be preserved; no entry is duplicated or lost except rejected pushes.
REQ-028 push_almost_full and pop_dw SHALL be combinational from registered occupancy.

Reset
REQ-029 clear SHALL asynchronously zero pointers, occupancies, pop_valid, pop_channel, drop_count, and error, set last_grant to NUM_CHANNELS-1 (channel 0 first), and discard any in-flight entry; memory contents are not reset.
REQ-030 pop_data SHALL reset to 0; clear asserted mid-transfer SHALL drop all queued entries with no partial outputs afterwards.

Structure
REQ-031 Package multi_fifo_channel_pkg SHALL hold DROP_CNT_W=16 and a function computing CH_W.
REQ-032 One sub-module sync_fifo_channel (single-channel FIFO with occupancy, full, empty) SHALL be instantiated per channel by a generate loop; the arbiter and output stage stay in the top module.

Verification
REQ-033 Push 0xA5 on ch2 at cycle 0, pop_ready=1 -> pop_valid=1, pop_data=0xA5, pop_channel=2 in cycle 2.
REQ-034 Preload 3 entries in each of ch0..ch3, pop_ready=1 -> channel order 0,1,2,3,0,1,2,3,0,1,2,3 at one per cycle.
REQ-035 Push 34 entries into ch1 with pop_ready=0 -> 33 accepted (32 FIFO + 1 output), drop_count[1]=1, error[1]=1, push_almost_full[1]=1 from occupancy 28.
REQ-036 Full ch0, same cycle push_en[0]=1 and pop_ready=1 -> push dropped, drop_count[0]+1, pop_dw[0]=31 next cycle.
REQ-037 Hold pop_ready=0 for 5 cycles with pop_valid=1 -> pop_data and pop_channel unchanged; clear asserted mid-sequence -> pop_valid=0, all pop_dw=0, error=0 immediately.
